// File: rtl/video_stream_framer.sv
// Frames a raw valid/ready pixel stream against a fixed WIDTH x HEIGHT raster and emits
// AXI4-Stream video with tuser (start of frame) and tlast (end of frame or line).
`timescale 1ns / 1ps

module video_stream_framer #(
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned HEIGHT     = 100,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned EOL_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic [15:0]           frame_count,
    output logic                  busy
);

    localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YLast = YW'(HEIGHT - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // eof marks the frame's final pixel independently of where tlast is placed
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  user;
        logic                  last;
        logic                  eof;
    } beat_t;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    beat_t         out_q, out_d, skid_q, skid_d, in_beat;
    logic          out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          in_fire, out_ready, x_end, y_end;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        skid_d        = skid_q;
        skid_valid_d  = skid_valid_q;
        frame_count_d = frame_count_q;

        s_axis_tready = (state_q == StActive) && !skid_valid_q;
        in_fire       = s_axis_tvalid && s_axis_tready;
        out_ready     = !out_valid_q || m_axis_tready;
        x_end         = (x_q == XLast);
        y_end         = (y_q == YLast);

        in_beat.data = s_axis_tdata;
        in_beat.user = (x_q == '0) && (y_q == '0);
        in_beat.eof  = x_end && y_end;
        in_beat.last = (EOL_MODE != 0) ? x_end : (x_end && y_end);

        case (state_q)
            StIdle:   if (enable) state_d = StActive;
            StActive: if (in_fire && x_end && y_end && !enable) state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (in_fire) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        // Skid holds the older beat, so it always drains into the output register first
        if (out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_d       = in_beat;
                out_valid_d = in_fire;
            end
        end else if (in_fire) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end

        if (out_valid_q && m_axis_tready && out_q.eof) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            skid_q        <= '0;
            skid_valid_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            skid_q        <= skid_d;
            skid_valid_q  <= skid_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_axis_tdata  = out_q.data;
    assign m_axis_tuser  = out_q.user;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tvalid = out_valid_q;
    assign frame_count   = frame_count_q;
    assign busy          = (state_q == StActive) || out_valid_q || skid_valid_q;

endmodule
